// File: rtl/punc_control_pkg.sv
// Shared PUnC defines: opcodes, controller states, datapath select encodings
// and the bundled control-word type.
package punc_control_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_EXEC2,
        ST_HALT
    } state_t;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RSV  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_t;

    localparam logic [1:0] PC_DATA_SEL_PC_OFF9  = 2'd0;
    localparam logic [1:0] PC_DATA_SEL_PC_OFF11 = 2'd1;
    localparam logic [1:0] PC_DATA_SEL_RQ       = 2'd2;

    localparam logic [1:0] DMEM_R_ADDR_SEL_PC      = 2'd0;
    localparam logic [1:0] DMEM_R_ADDR_SEL_PC_OFF9 = 2'd1;
    localparam logic [1:0] DMEM_R_ADDR_SEL_RP      = 2'd2;
    localparam logic [1:0] DMEM_R_ADDR_SEL_RQ_OFF6 = 2'd3;

    localparam logic [1:0] DMEM_W_ADDR_SEL_PC_OFF9 = 2'd0;
    localparam logic [1:0] DMEM_W_ADDR_SEL_TEMP    = 2'd1;
    localparam logic [1:0] DMEM_W_ADDR_SEL_RQ_OFF6 = 2'd2;

    localparam logic [1:0] RF_W_DATA_SEL_ALU     = 2'd0;
    localparam logic [1:0] RF_W_DATA_SEL_PC_OFF9 = 2'd1;
    localparam logic [1:0] RF_W_DATA_SEL_MEM     = 2'd2;
    localparam logic [1:0] RF_W_DATA_SEL_PC      = 2'd3;

    // Zero selects the destination field so an unnamed write address means ir[11:9].
    localparam logic RF_W_ADDR_SEL_11_9 = 1'b0;
    localparam logic RF_W_ADDR_SEL_R7   = 1'b1;

    localparam logic RF_RP_ADDR_SEL_11_9 = 1'b0;
    localparam logic RF_RP_ADDR_SEL_2_0  = 1'b1;

    localparam logic [1:0] ALU_PASS_A = 2'd0;
    localparam logic [1:0] ALU_ADD    = 2'd1;
    localparam logic [1:0] ALU_AND    = 2'd2;
    localparam logic [1:0] ALU_NOT_B  = 2'd3;

    localparam logic ALU_IN_A_SEL_RP  = 1'b0;
    localparam logic ALU_IN_A_SEL_4_0 = 1'b1;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld;
        logic       ir_clr;
        logic       dmem_rd;
        logic       dmem_wr;
        logic [1:0] dmem_r_addr_sel;
        logic [1:0] dmem_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       rf_w_wr;
        logic       rf_rp_addr_sel;
        logic       rf_rp_rd;
        logic       rf_rq_rd;
        logic       temp_ld;
        logic       nzp_ld;
        logic       nzp_clr;
        logic [1:0] alu_sel;
        logic       alu_in_a_sel;
        logic       halted;
    } ctrl_t;

    function automatic opcode_t opcode_of(input logic [15:0] instr);
        return opcode_t'(instr[15:12]);
    endfunction

endpackage

// File: rtl/punc_control_if.sv
// Controller <-> datapath bundle: control selects/enables one way, IR and
// branch-match flag back.
interface punc_control_if;
    logic [15:0] ir;
    logic        nzp_match;
    logic        pc_ld;
    logic        pc_clr;
    logic        pc_inc;
    logic [1:0]  pc_sel;
    logic        ir_ld;
    logic        ir_clr;
    logic        dmem_rd;
    logic        dmem_wr;
    logic [1:0]  dmem_r_addr_sel;
    logic [1:0]  dmem_w_addr_sel;
    logic [1:0]  rf_w_data_sel;
    logic        rf_w_addr_sel;
    logic        rf_w_wr;
    logic        rf_rp_addr_sel;
    logic        rf_rp_rd;
    logic        rf_rq_rd;
    logic        temp_ld;
    logic        nzp_ld;
    logic        nzp_clr;
    logic [1:0]  alu_sel;
    logic        alu_in_a_sel;
    logic        halted;

    modport master (
        input  ir, nzp_match,
        output pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, dmem_rd, dmem_wr,
               dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel,
               rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld,
               nzp_clr, alu_sel, alu_in_a_sel, halted
    );

    modport slave (
        output ir, nzp_match,
        input  pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, dmem_rd, dmem_wr,
               dmem_r_addr_sel, dmem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel,
               rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld,
               nzp_clr, alu_sel, alu_in_a_sel, halted
    );
endinterface

// File: rtl/punc_control.sv
// PUnC LC3 sequencing FSM: FETCH / DECODE / EXEC (/ EXEC2 for LDI, STI) / HALT,
// with control outputs decoded combinationally from state, IR and nzp_match.
module punc_control
    import punc_control_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    punc_control_if.master bus
);

    state_t  state;
    state_t  state_next;
    ctrl_t   c;
    opcode_t op;

    assign op = opcode_of(bus.ir);

    always_ff @(posedge clk) begin
        if (rst) state <= ST_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        c          = '0;
        state_next = state;
        case (state)
            ST_FETCH: begin
                c.dmem_r_addr_sel = DMEM_R_ADDR_SEL_PC;
                c.dmem_rd         = 1'b1;
                c.ir_ld           = 1'b1;
                c.pc_inc          = 1'b1;
                state_next        = ST_DECODE;
            end
            ST_DECODE: state_next = ST_EXEC;
            ST_EXEC: begin
                state_next = ST_FETCH;
                case (op)
                    OP_ADD, OP_AND: begin
                        c.rf_rp_addr_sel = RF_RP_ADDR_SEL_2_0;
                        c.alu_in_a_sel   = bus.ir[5] ? ALU_IN_A_SEL_4_0 : ALU_IN_A_SEL_RP;
                        c.alu_sel        = (op == OP_ADD) ? ALU_ADD : ALU_AND;
                        c.rf_w_data_sel  = RF_W_DATA_SEL_ALU;
                        c.rf_w_addr_sel  = RF_W_ADDR_SEL_11_9;
                        c.rf_w_wr        = 1'b1;
                        c.nzp_ld         = 1'b1;
                    end
                    OP_NOT: begin
                        c.alu_sel       = ALU_NOT_B;
                        c.rf_w_data_sel = RF_W_DATA_SEL_ALU;
                        c.rf_w_addr_sel = RF_W_ADDR_SEL_11_9;
                        c.rf_w_wr       = 1'b1;
                        c.nzp_ld        = 1'b1;
                    end
                    OP_LD, OP_LDR: begin
                        c.dmem_r_addr_sel = (op == OP_LD) ? DMEM_R_ADDR_SEL_PC_OFF9
                                                          : DMEM_R_ADDR_SEL_RQ_OFF6;
                        c.rf_w_data_sel   = RF_W_DATA_SEL_MEM;
                        c.rf_w_addr_sel   = RF_W_ADDR_SEL_11_9;
                        c.rf_w_wr         = 1'b1;
                        c.nzp_ld          = 1'b1;
                    end
                    OP_LEA: begin
                        c.rf_w_data_sel = RF_W_DATA_SEL_PC_OFF9;
                        c.rf_w_wr       = 1'b1;
                        c.nzp_ld        = 1'b1;
                    end
                    OP_ST, OP_STR: begin
                        c.dmem_w_addr_sel = (op == OP_ST) ? DMEM_W_ADDR_SEL_PC_OFF9
                                                          : DMEM_W_ADDR_SEL_RQ_OFF6;
                        c.rf_rp_addr_sel  = RF_RP_ADDR_SEL_11_9;
                        c.dmem_wr         = 1'b1;
                    end
                    OP_BR: begin
                        c.pc_sel = PC_DATA_SEL_PC_OFF9;
                        c.pc_ld  = bus.nzp_match;
                    end
                    OP_JMP: begin
                        c.pc_sel = PC_DATA_SEL_RQ;
                        c.pc_ld  = 1'b1;
                    end
                    // Link and jump share one edge; Rq is read before R7 is overwritten.
                    OP_JSR: begin
                        c.rf_w_addr_sel = RF_W_ADDR_SEL_R7;
                        c.rf_w_data_sel = RF_W_DATA_SEL_PC;
                        c.rf_w_wr       = 1'b1;
                        c.pc_sel        = bus.ir[11] ? PC_DATA_SEL_PC_OFF11 : PC_DATA_SEL_RQ;
                        c.pc_ld         = 1'b1;
                    end
                    OP_LDI, OP_STI: begin
                        c.dmem_r_addr_sel = DMEM_R_ADDR_SEL_PC_OFF9;
                        c.temp_ld         = 1'b1;
                        state_next        = ST_EXEC2;
                    end
                    OP_TRAP: state_next = ST_HALT;
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                state_next = ST_FETCH;
                if (op == OP_LDI) begin
                    c.rf_w_data_sel = RF_W_DATA_SEL_MEM;
                    c.rf_w_wr       = 1'b1;
                    c.nzp_ld        = 1'b1;
                end else if (op == OP_STI) begin
                    c.dmem_w_addr_sel = DMEM_W_ADDR_SEL_TEMP;
                    c.rf_rp_addr_sel  = RF_RP_ADDR_SEL_11_9;
                    c.dmem_wr         = 1'b1;
                end
            end
            ST_HALT: c.halted = 1'b1;
            default: state_next = ST_FETCH;
        endcase
        if (rst) begin
            c          = '0;
            c.pc_clr   = 1'b1;
            c.ir_clr   = 1'b1;
            c.nzp_clr  = 1'b1;
            state_next = ST_FETCH;
        end
    end

    logic unused_ir;
    assign unused_ir = &{1'b0, bus.ir[10:6], bus.ir[4:0]};

    assign bus.pc_ld           = c.pc_ld;
    assign bus.pc_clr          = c.pc_clr;
    assign bus.pc_inc          = c.pc_inc;
    assign bus.pc_sel          = c.pc_sel;
    assign bus.ir_ld           = c.ir_ld;
    assign bus.ir_clr          = c.ir_clr;
    assign bus.dmem_rd         = c.dmem_rd;
    assign bus.dmem_wr         = c.dmem_wr;
    assign bus.dmem_r_addr_sel = c.dmem_r_addr_sel;
    assign bus.dmem_w_addr_sel = c.dmem_w_addr_sel;
    assign bus.rf_w_data_sel   = c.rf_w_data_sel;
    assign bus.rf_w_addr_sel   = c.rf_w_addr_sel;
    assign bus.rf_w_wr         = c.rf_w_wr;
    assign bus.rf_rp_addr_sel  = c.rf_rp_addr_sel;
    assign bus.rf_rp_rd        = c.rf_rp_rd;
    assign bus.rf_rq_rd        = c.rf_rq_rd;
    assign bus.temp_ld         = c.temp_ld;
    assign bus.nzp_ld          = c.nzp_ld;
    assign bus.nzp_clr         = c.nzp_clr;
    assign bus.alu_sel         = c.alu_sel;
    assign bus.alu_in_a_sel    = c.alu_in_a_sel;
    assign bus.halted          = c.halted;

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: each instruction is expanded into its expected
// per-cycle control words and compared cycle by cycle against the DUT.
module tb_punc_control;
    import punc_control_pkg::*;

    logic clk;
    logic rst;
    int unsigned n_cmp;
    int unsigned n_bad;

    punc_control_if bus ();

    punc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic ctrl_t observed();
        ctrl_t o;
        o.pc_ld           = bus.pc_ld;
        o.pc_clr          = bus.pc_clr;
        o.pc_inc          = bus.pc_inc;
        o.pc_sel          = bus.pc_sel;
        o.ir_ld           = bus.ir_ld;
        o.ir_clr          = bus.ir_clr;
        o.dmem_rd         = bus.dmem_rd;
        o.dmem_wr         = bus.dmem_wr;
        o.dmem_r_addr_sel = bus.dmem_r_addr_sel;
        o.dmem_w_addr_sel = bus.dmem_w_addr_sel;
        o.rf_w_data_sel   = bus.rf_w_data_sel;
        o.rf_w_addr_sel   = bus.rf_w_addr_sel;
        o.rf_w_wr         = bus.rf_w_wr;
        o.rf_rp_addr_sel  = bus.rf_rp_addr_sel;
        o.rf_rp_rd        = bus.rf_rp_rd;
        o.rf_rq_rd        = bus.rf_rq_rd;
        o.temp_ld         = bus.temp_ld;
        o.nzp_ld          = bus.nzp_ld;
        o.nzp_clr         = bus.nzp_clr;
        o.alu_sel         = bus.alu_sel;
        o.alu_in_a_sel    = bus.alu_in_a_sel;
        o.halted          = bus.halted;
        return o;
    endfunction

    // Number of cycles an instruction occupies, FETCH included.
    function automatic int unsigned instr_len(input logic [15:0] instr);
        logic [3:0] op;
        op = instr[15:12];
        return (op == 4'b1010 || op == 4'b1011) ? 4 : 3;
    endfunction

    function automatic ctrl_t reset_word();
        ctrl_t e;
        e = '0;
        e.pc_clr  = 1'b1;
        e.ir_clr  = 1'b1;
        e.nzp_clr = 1'b1;
        return e;
    endfunction

    function automatic ctrl_t halt_word();
        ctrl_t e;
        e = '0;
        e.halted = 1'b1;
        return e;
    endfunction

    // Expected control word for cycle 'phase' of an instruction (0 = fetch).
    function automatic ctrl_t expect_word(input logic [15:0] instr, input logic match,
                                          input int unsigned phase);
        ctrl_t      e;
        logic [3:0] op;
        logic       writes_dr;
        e  = '0;
        op = instr[15:12];
        writes_dr = 1'b0;
        if (phase == 0) begin
            e.dmem_rd = 1'b1; e.ir_ld = 1'b1; e.pc_inc = 1'b1;
            e.dmem_r_addr_sel = DMEM_R_ADDR_SEL_PC;
        end else if (phase == 2) begin
            if (op == 4'b0001 || op == 4'b0101) begin
                e.rf_rp_addr_sel = RF_RP_ADDR_SEL_2_0;
                e.alu_in_a_sel   = instr[5];
                e.alu_sel        = (op == 4'b0001) ? ALU_ADD : ALU_AND;
                writes_dr        = 1'b1;
            end
            if (op == 4'b1001) begin
                e.alu_sel = ALU_NOT_B;
                writes_dr = 1'b1;
            end
            if (op == 4'b0010 || op == 4'b0110) begin
                e.dmem_r_addr_sel = (op == 4'b0010) ? DMEM_R_ADDR_SEL_PC_OFF9 : DMEM_R_ADDR_SEL_RQ_OFF6;
                e.rf_w_data_sel   = RF_W_DATA_SEL_MEM;
                writes_dr         = 1'b1;
            end
            if (op == 4'b1110) begin
                e.rf_w_data_sel = RF_W_DATA_SEL_PC_OFF9;
                writes_dr       = 1'b1;
            end
            if (writes_dr) begin
                e.rf_w_addr_sel = RF_W_ADDR_SEL_11_9;
                e.rf_w_wr = 1'b1;
                e.nzp_ld  = 1'b1;
            end
            if (op == 4'b0011 || op == 4'b0111) begin
                e.dmem_w_addr_sel = (op == 4'b0011) ? DMEM_W_ADDR_SEL_PC_OFF9 : DMEM_W_ADDR_SEL_RQ_OFF6;
                e.rf_rp_addr_sel  = RF_RP_ADDR_SEL_11_9;
                e.dmem_wr         = 1'b1;
            end
            if (op == 4'b0000) begin
                e.pc_sel = PC_DATA_SEL_PC_OFF9;
                e.pc_ld  = match;
            end
            if (op == 4'b1100) begin
                e.pc_sel = PC_DATA_SEL_RQ;
                e.pc_ld  = 1'b1;
            end
            if (op == 4'b0100) begin
                e.rf_w_addr_sel = RF_W_ADDR_SEL_R7;
                e.rf_w_data_sel = RF_W_DATA_SEL_PC;
                e.rf_w_wr       = 1'b1;
                e.pc_sel        = instr[11] ? PC_DATA_SEL_PC_OFF11 : PC_DATA_SEL_RQ;
                e.pc_ld         = 1'b1;
            end
            if (op == 4'b1010 || op == 4'b1011) begin
                e.dmem_r_addr_sel = DMEM_R_ADDR_SEL_PC_OFF9;
                e.temp_ld         = 1'b1;
            end
        end else if (phase == 3) begin
            if (op == 4'b1010) begin
                e.rf_w_data_sel = RF_W_DATA_SEL_MEM;
                e.rf_w_wr = 1'b1;
                e.nzp_ld  = 1'b1;
            end else begin
                e.dmem_w_addr_sel = DMEM_W_ADDR_SEL_TEMP;
                e.rf_rp_addr_sel  = RF_RP_ADDR_SEL_11_9;
                e.dmem_wr         = 1'b1;
            end
        end
        return e;
    endfunction

    // Called just after a rising edge: compare on the falling edge, then
    // advance to 1 time unit past the next rising edge.
    task automatic step(input string tag, input ctrl_t exp);
        ctrl_t obs;
        @(negedge clk);
        obs = observed();
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input string tag, input logic [15:0] instr, input logic match);
        for (int unsigned p = 0; p < instr_len(instr); p++) begin
            if (p == 1) bus.ir = instr;
            bus.nzp_match = match;
            step($sformatf("%s[%h].c%0d", tag, instr, p), expect_word(instr, match, p));
        end
    endtask

    initial begin
        logic [15:0] instr;
        logic        m;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        bus.ir = 16'h0000;
        bus.nzp_match = 1'b0;
        @(posedge clk);
        #1;
        step("reset_hold0", reset_word());
        step("reset_hold1", reset_word());
        rst = 1'b0;

        run_instr("add_imm", 16'h12BD, 1'b0);
        run_instr("brz_taken", 16'h0404, 1'b1);
        run_instr("brz_not_taken", 16'h0404, 1'b0);
        run_instr("jsrr_r7", 16'h41C0, 1'b0);
        run_instr("jsr_off11", 16'h4805, 1'b1);
        run_instr("ldi", 16'hA602, 1'b0);
        run_instr("and_reg", 16'h5242, 1'b0);
        run_instr("rti_nop", 16'h8000, 1'b1);
        run_instr("rsv_nop", 16'hD123, 1'b1);

        for (int unsigned i = 0; i < 300; i++) begin
            instr = 16'($urandom);
            if (instr[15:12] == 4'hF) instr[15:12] = 4'($urandom_range(0, 14));
            m = 1'($urandom_range(0, 1));
            run_instr("rand", instr, m);
        end

        // Reset arriving in the second execute cycle of STI.
        instr = 16'hB405;
        bus.nzp_match = 1'b0;
        step("sti_rst.c0", expect_word(instr, 1'b0, 0));
        bus.ir = instr;
        step("sti_rst.c1", expect_word(instr, 1'b0, 1));
        step("sti_rst.c2", expect_word(instr, 1'b0, 2));
        rst = 1'b1;
        step("sti_rst.exec2_reset", reset_word());
        rst = 1'b0;
        step("sti_rst.refetch", expect_word(instr, 1'b0, 0));
        bus.ir = 16'h1042;
        step("after_rst.c1", expect_word(16'h1042, 1'b0, 1));
        step("after_rst.c2", expect_word(16'h1042, 1'b0, 2));

        // TRAP: parks in HALT until reset.
        instr = 16'hF025;
        step("trap.c0", expect_word(instr, 1'b0, 0));
        bus.ir = instr;
        step("trap.c1", expect_word(instr, 1'b0, 1));
        step("trap.c2", expect_word(instr, 1'b0, 2));
        for (int unsigned i = 0; i < 20; i++) begin
            bus.nzp_match = 1'($urandom_range(0, 1));
            bus.ir = (i % 2 == 0) ? 16'h1042 : instr;
            step($sformatf("halt.c%0d", i), halt_word());
        end
        rst = 1'b1;
        step("halt_reset", reset_word());
        rst = 1'b0;
        run_instr("post_halt", 16'h2A10, 1'b0);
        step("final_fetch", expect_word(16'h0000, 1'b0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
